r__mc_ctrl: RTL
===============

Name: rı_mc_ctrl

Overview:
- Multi-cycle control unit for the R/I CPU datapath (pc, OP_YIMA fields, Register_file, ALU, RAM_B data memory).
- Sequences each instruction through IF/ID/EX/MEM/WB states and emits one-cycle strobes.
  - PC update, IR load, register write, memory write.
- Holds datapath select lines stable while an instruction executes.
- Waits out the data-memory latency and counts retired instructions.

Parameters:
- MEM_LAT, 1, cycles spent in MEM state (RAM_B read/write latency); legal range 1..7.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-low.
- op  in  6  Inst_code[31:26] from the IR; sampled in ID.
- func  in  6  Inst_code[5:0] from the IR; sampled in ID.
- PC_Write  out  1  PC <= PC+4 strobe.
- IR_Write  out  1  instruction register load strobe.
- Write_Reg  out  1  register file write strobe.
- Mem_Write  out  1  RAM_B wea.
- rd_rt_s  out  1  1 = write address is rt.
- imm_s  out  1  1 = sign-extend imm, 0 = zero-extend.
- rt_imm_s  out  1  1 = ALU_B is immediate.
- alu_mem_s  out  1  1 = W_Data is memory data.
- ALU_OP  out  3  ALU operation.
- state  out  3  current state encoding, for debug LEDs.
- instr_done  out  1  pulses in the final cycle of each instruction.
- illegal  out  1  sticky; set when an undefined op/func is decoded.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- State encoding: S_INIT=0, S_IF=1, S_ID=2, S_EX=3, S_MEM=4, S_WB=5, S_HALT=6, S_WAIT=7 (S_WAIT only with the optional feature).
- Reset: at any edge with rst=0, regardless of current state:
  - state <= S_INIT; latched op/func <= 0; MEM counter <= 0; retired <= 0; illegal <= 0.
  - All outputs are decoded from state, so in S_INIT every strobe and select is 0 and ALU_OP=000.
- S_INIT -> S_IF unconditionally.
- S_IF: IR_Write=1 and PC_Write=1 for exactly one cycle -> S_ID.
- S_ID: latch op and func; decode. Undefined code -> S_HALT, otherwise -> S_EX.
- Decode table (ALU_OP: AND 000, OR 001, XOR 010, NOR 011, ADD 100, SUB 101, SLTU 110, SLLV 111):
  - op=000000 R-type: func 100100/100101/100110/100111/100000/100010/101011/000100 map to 000..111 in the order listed above. rd_rt_s=0, rt_imm_s=0, imm_s=0.
  - addi 001000 -> ADD, imm_s=1; andi 001100 -> AND, imm_s=0; ori 001101 -> OR, imm_s=0; xori 001110 -> XOR, imm_s=0; sltiu 001011 -> SLTU, imm_s=1.
  - lw 100011 and sw 101011 -> ADD, imm_s=1.
  - All I-type: rd_rt_s=1, rt_imm_s=1.
  - alu_mem_s=1 only for lw.
- Select lines (rd_rt_s, imm_s, rt_imm_s, alu_mem_s, ALU_OP) are driven from the latched code during S_EX, S_MEM and S_WB, and are 0 in every other state.
- S_EX: ALU-class instruction -> S_WB; lw/sw -> S_MEM with counter <= MEM_LAT-1.
- S_MEM:
  - Mem_Write=1 only in the first MEM cycle, and only for sw.
  - Counter decrements each cycle. At 0: lw -> S_WB; sw -> S_IF with instr_done=1.
- S_WB: Write_Reg=1 and instr_done=1 -> S_IF.
- Cycle counts: ALU instruction 4; lw 4+MEM_LAT; sw 3+MEM_LAT.
- retired increments in every cycle where instr_done=1 and wraps at 2^CNT_W to 0.
- S_HALT: all strobes 0, illegal=1, instr_done=0. Only reset exits this state.
- op/func changes outside S_ID have no effect.

Optional Feature:
- Macro: RI_MC_STEP_MODE_EN.
- With the macro defined:
  - Extra input step (1 bit, already synchronised by the board debounce).
  - Every instr_done cycle goes to S_WAIT instead of S_IF.
  - S_WAIT leaves to S_IF on the first cycle where step=1 and step was 0 in the previous cycle (rising-edge detect register, reset to 0).
  - A step held high advances exactly one instruction.
  - All strobes are 0 in S_WAIT.
- Without the macro: no step port, no S_WAIT state, and instructions run back-to-back.

Decomposition:
- Package ri_ctrl_pkg holds:
  - state encodings;
  - opcode constants (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU, OP_LW, OP_SW);
  - func constants;
  - ALU_OP codes.
- Sub-module ri_inst_decode: combinational op/func -> {ALU_OP, selects, class(alu/lw/sw), illegal}. The FSM stays in rı_mc_ctrl.

Test Plan:
- Reset: hold rst=0 for 3 edges, release -> state=0 for one cycle, then IF with IR_Write=PC_Write=1; retired=0.
- add (op=0, func=100000) -> 4 cycles; ALU_OP=100, rd_rt_s=0, one Write_Reg pulse in cycle 4; retired=1.
- lw with MEM_LAT=3 -> 7 cycles; Mem_Write never 1; alu_mem_s=1 and Write_Reg=1 only in WB; rd_rt_s=1, imm_s=1.
- sw with MEM_LAT=1 -> 4 cycles; exactly one Mem_Write pulse; Write_Reg never 1; instr_done in MEM.
- op=111111 -> state 6 after ID, illegal=1 sticky, no strobes for 20 cycles; rst=0 clears it.
- Step mode (macro set): after an andi, FSM sits in state 7; step held high 10 cycles advances exactly one instruction; rst=0 during S_MEM of sw aborts with no further Mem_Write.

Source files
------------

// File: rtl/ri_ctrl_pkg.sv
// Shared definitions for the R/I multi-cycle control unit: FSM state encodings,
// opcode/func constants, ALU operation codes and the decoder result types.
package ri_ctrl_pkg;

  // Encodings are fixed because the debug LEDs display them directly.
  typedef enum logic [2:0] {
    StInit = 3'd0,
    StIf   = 3'd1,
    StId   = 3'd2,
    StEx   = 3'd3,
    StMem  = 3'd4,
    StWb   = 3'd5,
    StHalt = 3'd6,
    StWait = 3'd7
  } state_e;

  // Inst_code[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Inst_code[5:0] for R-type
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_XOR  = 6'b100110;
  localparam logic [5:0] FUNC_NOR  = 6'b100111;
  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_SLTU = 6'b101011;
  localparam logic [5:0] FUNC_SLLV = 6'b000100;

  typedef enum logic [2:0] {
    AluAnd  = 3'b000,
    AluOr   = 3'b001,
    AluXor  = 3'b010,
    AluNor  = 3'b011,
    AluAdd  = 3'b100,
    AluSub  = 3'b101,
    AluSltu = 3'b110,
    AluSllv = 3'b111
  } alu_op_e;

  // Instruction class decides the EX/MEM/WB path.
  typedef enum logic [1:0] {
    ClsAlu = 2'd0,
    ClsLw  = 2'd1,
    ClsSw  = 2'd2
  } inst_cls_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    rd_rt_s;
    logic    imm_s;
    logic    rt_imm_s;
    logic    alu_mem_s;
  } sel_t;

endpackage

// File: rtl/ri_inst_decode.sv
// Combinational instruction decoder for the R/I CPU.
// Ports:
//   op, func  - opcode and function fields of the instruction
//   sel       - ALU operation and datapath select lines
//   cls       - instruction class (ALU, load, store)
//   illegal   - op/func combination is not a defined instruction
module ri_inst_decode
  import ri_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output sel_t       sel,
  output inst_cls_e  cls,
  output logic       illegal
);

  logic itype;

  always_comb begin
    sel     = '0;
    cls     = ClsAlu;
    illegal = 1'b0;
    itype   = 1'b1;
    case (op)
      OP_RTYPE: begin
        itype = 1'b0;
        case (func)
          FUNC_AND:  sel.alu_op = AluAnd;
          FUNC_OR:   sel.alu_op = AluOr;
          FUNC_XOR:  sel.alu_op = AluXor;
          FUNC_NOR:  sel.alu_op = AluNor;
          FUNC_ADD:  sel.alu_op = AluAdd;
          FUNC_SUB:  sel.alu_op = AluSub;
          FUNC_SLTU: sel.alu_op = AluSltu;
          FUNC_SLLV: sel.alu_op = AluSllv;
          default:   illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        sel.alu_op = AluAdd;
        sel.imm_s  = 1'b1;
      end
      OP_ANDI:  sel.alu_op = AluAnd;
      OP_ORI:   sel.alu_op = AluOr;
      OP_XORI:  sel.alu_op = AluXor;
      OP_SLTIU: begin
        sel.alu_op = AluSltu;
        sel.imm_s  = 1'b1;
      end
      OP_LW: begin
        sel.alu_op    = AluAdd;
        sel.imm_s     = 1'b1;
        sel.alu_mem_s = 1'b1;
        cls           = ClsLw;
      end
      OP_SW: begin
        sel.alu_op = AluAdd;
        sel.imm_s  = 1'b1;
        cls        = ClsSw;
      end
      default: begin
        itype   = 1'b0;
        illegal = 1'b1;
      end
    endcase

    if (itype) begin
      sel.rd_rt_s  = 1'b1;
      sel.rt_imm_s = 1'b1;
    end
    // Keep selects quiet for undefined codes.
    if (illegal) begin
      sel = '0;
    end
  end

endmodule

// File: rtl/r__mc_ctrl.sv
// Multi-cycle control unit for the R/I CPU datapath. Sequences each
// instruction through IF/ID/EX/MEM/WB, emits one-cycle strobes, holds the
// datapath selects during execution and counts retired instructions.
// Optional build macro: RI_MC_STEP_MODE_EN adds the 'step' input and a
// wait state after every instruction (single-step debugging).
// Ports:
//   clk, rst              - clock, synchronous active-low reset
//   step                  - single-step request (step-mode builds only)
//   op, func              - IR fields, sampled in ID
//   PC_Write, IR_Write    - fetch strobes
//   Write_Reg, Mem_Write  - register file / RAM_B write strobes
//   rd_rt_s, imm_s, rt_imm_s, alu_mem_s, ALU_OP - datapath selects
//   state                 - current state encoding
//   instr_done, illegal, retired - status
module r__mc_ctrl
  import ri_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,  // 1..7
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef RI_MC_STEP_MODE_EN
  input  logic             step,
`endif
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  output logic             PC_Write,
  output logic             IR_Write,
  output logic             Write_Reg,
  output logic             Mem_Write,
  output logic             rd_rt_s,
  output logic             imm_s,
  output logic             rt_imm_s,
  output logic             alu_mem_s,
  output logic [2:0]       ALU_OP,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] MemCntInit = 3'(MEM_LAT - 1);

`ifdef RI_MC_STEP_MODE_EN
  localparam state_e DoneNext = StWait;
`else
  localparam state_e DoneNext = StIf;
`endif

  state_e           state_q, state_d;
  logic [5:0]       op_q, func_q;
  logic [2:0]       mem_cnt_q, mem_cnt_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q;

  logic [5:0] dec_op, dec_func;
  sel_t       dec_sel;
  inst_cls_e  dec_cls;
  logic       dec_illegal;
  logic       drive_sel;

  // In ID the decision needs the incoming code; afterwards only the latched
  // copy matters, so later IR changes cannot disturb a running instruction.
  assign dec_op   = (state_q == StId) ? op   : op_q;
  assign dec_func = (state_q == StId) ? func : func_q;

  ri_inst_decode u_decode (
    .op      (dec_op),
    .func    (dec_func),
    .sel     (dec_sel),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

`ifdef RI_MC_STEP_MODE_EN
  logic step_prev_q;
  logic step_rise;

  assign step_rise = step & ~step_prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= step;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    mem_cnt_d  = mem_cnt_q;
    illegal_d  = illegal_q;
    PC_Write   = 1'b0;
    IR_Write   = 1'b0;
    Write_Reg  = 1'b0;
    Mem_Write  = 1'b0;
    instr_done = 1'b0;
    drive_sel  = 1'b0;

    unique case (state_q)
      StInit: state_d = StIf;
      StIf: begin
        PC_Write = 1'b1;
        IR_Write = 1'b1;
        state_d  = StId;
      end
      StId: begin
        if (dec_illegal) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else begin
          state_d = StEx;
        end
      end
      StEx: begin
        drive_sel = 1'b1;
        if (dec_cls == ClsAlu) begin
          state_d = StWb;
        end else begin
          state_d   = StMem;
          mem_cnt_d = MemCntInit;
        end
      end
      StMem: begin
        drive_sel = 1'b1;
        // The counter starts at MEM_LAT-1, so that value marks the first cycle.
        Mem_Write = (dec_cls == ClsSw) && (mem_cnt_q == MemCntInit);
        if (mem_cnt_q == 3'd0) begin
          if (dec_cls == ClsLw) begin
            state_d = StWb;
          end else begin
            instr_done = 1'b1;
            state_d    = DoneNext;
          end
        end else begin
          mem_cnt_d = mem_cnt_q - 3'd1;
        end
      end
      StWb: begin
        drive_sel  = 1'b1;
        Write_Reg  = 1'b1;
        instr_done = 1'b1;
        state_d    = DoneNext;
      end
      StHalt: state_d = StHalt;
      StWait: begin
`ifdef RI_MC_STEP_MODE_EN
        if (step_rise) begin
          state_d = StIf;
        end
`else
        state_d = StInit;
`endif
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    rd_rt_s   = 1'b0;
    imm_s     = 1'b0;
    rt_imm_s  = 1'b0;
    alu_mem_s = 1'b0;
    ALU_OP    = 3'b000;
    if (drive_sel) begin
      rd_rt_s   = dec_sel.rd_rt_s;
      imm_s     = dec_sel.imm_s;
      rt_imm_s  = dec_sel.rt_imm_s;
      alu_mem_s = dec_sel.alu_mem_s;
      ALU_OP    = dec_sel.alu_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StInit;
      op_q      <= 6'd0;
      func_q    <= 6'd0;
      mem_cnt_q <= 3'd0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      mem_cnt_q <= mem_cnt_d;
      illegal_q <= illegal_d;
      if (state_q == StId) begin
        op_q   <= op;
        func_q <= func;
      end
      if (instr_done) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
